// File: rtl/qc_decoder_if.sv
// qc_decoder_if: handshake and data bundle for the QC-LDPC bit-flipping decoder.
//   valid/ready : input handshake (word accepted when both are high)
//   code_in     : 189-bit received word, [188:162] info bits, [161:0] parity
//   g_rows      : 27 x 162 parity-generator rows, g_rows[i][j] = P[i][j]
//   data_out    : corrected 27-bit information word
//   out_valid   : one-cycle result strobe
//   dec_ok      : final syndrome was all-zero
//   iter_cnt    : number of flip iterations performed
interface qc_decoder_if #(
    parameter int ITER_W = 4
);
    logic                  valid;
    logic                  ready;
    logic [188:0]          code_in;
    logic [26:0][161:0]    g_rows;
    logic [26:0]           data_out;
    logic                  out_valid;
    logic                  dec_ok;
    logic [ITER_W-1:0]     iter_cnt;

    modport master (
        output valid, code_in, g_rows,
        input  ready, data_out, out_valid, dec_ok, iter_cnt
    );

    modport slave (
        input  valid, code_in, g_rows,
        output ready, data_out, out_valid, dec_ok, iter_cnt
    );
endinterface

// File: rtl/qc_decoder.sv
// qc_decoder: hard-decision bit-flipping decoder for the systematic
// 27+162 QC-LDPC code. A word accepted in IDLE is checked against every
// parity equation; information bits failing a strict majority of their
// checks are flipped, and the loop repeats until the syndrome clears, the
// iteration limit is hit, or no bit qualifies for flipping.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : qc_decoder_if slave (handshake, codeword, P rows, results)
module qc_decoder #(
    parameter int MAX_ITER = 8,
    parameter int ITER_W   = 4
) (
    input  logic          clk,
    input  logic          rst,
    qc_decoder_if.slave   bus
);

    localparam logic [ITER_W-1:0] MAX_ITER_L = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ITER_ONE   = {{(ITER_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYND = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of set bits in a 162-bit vector; the result always fits 8 bits.
    function automatic logic [7:0] popcount162(input logic [161:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int k = 0; k < 162; k++) begin
            cnt = cnt + {7'd0, v[k]};
        end
        return cnt;
    endfunction

    // Even-parity reduction of one syndrome column contribution.
    function automatic logic parity27(input logic [26:0] v);
        return ^v;
    endfunction

    state_t             state_r;
    state_t             state_nxt;
    logic [26:0]        d_reg;
    logic [161:0]       p_reg;
    logic [161:0]       syn_r;
    logic [26:0]        mask_r;
    logic [ITER_W-1:0]  iter_r;
    logic [161:0]       syn_s;
    logic [26:0]        mask_s;
    logic               load_s;
    logic               flip_s;
    logic               finish_s;
    logic               ok_s;
    logic               ready_r;
    logic               out_valid_r;
    logic               dec_ok_r;
    logic [26:0]        data_out_r;
    logic [ITER_W-1:0]  iter_cnt_r;

    // Syndrome of the current working word: each parity bit against its column of P.
    always_comb begin
        logic [26:0] col;
        syn_s = {162{1'b0}};
        col   = 27'd0;
        for (int j = 0; j < 162; j++) begin
            for (int i = 0; i < 27; i++) begin
                col[i] = bus.g_rows[i][j];
            end
            syn_s[j] = p_reg[j] ^ parity27(d_reg & col);
        end
    end

    // Flip mask: a bit flips when strictly more than half of its checks fail.
    // 2*u is kept 9 bits wide so it cannot wrap; a zero-weight row never flips.
    always_comb begin
        logic [7:0] u_v;
        logic [7:0] w_v;
        mask_s = 27'd0;
        u_v    = 8'd0;
        w_v    = 8'd0;
        for (int i = 0; i < 27; i++) begin
            u_v       = popcount162(syn_s & bus.g_rows[i]);
            w_v       = popcount162(bus.g_rows[i]);
            mask_s[i] = ({u_v, 1'b0} > {1'b0, w_v});
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state and control decode; EVAL exits are checked in priority order.
    always_comb begin
        state_nxt = state_r;
        load_s    = 1'b0;
        flip_s    = 1'b0;
        finish_s  = 1'b0;
        ok_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.valid && ready_r) begin
                    load_s    = 1'b1;
                    state_nxt = ST_SYND;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SYND: begin
                state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                if (syn_r == {162{1'b0}}) begin
                    ok_s      = 1'b1;
                    finish_s  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (iter_r == MAX_ITER_L) begin
                    finish_s  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (mask_r == 27'd0) begin
                    finish_s  = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    flip_s    = 1'b1;
                    state_nxt = ST_SYND;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Working registers: load on accept, flip on a failed evaluation,
    // capture syndrome and mask in SYND. Parity bits are never modified.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_reg  <= 27'd0;
            p_reg  <= {162{1'b0}};
            iter_r <= {ITER_W{1'b0}};
            syn_r  <= {162{1'b0}};
            mask_r <= 27'd0;
        end else begin
            if (load_s) begin
                d_reg  <= bus.code_in[188:162];
                p_reg  <= bus.code_in[161:0];
                iter_r <= {ITER_W{1'b0}};
            end else if (flip_s) begin
                d_reg  <= d_reg ^ mask_r;
                iter_r <= iter_r + ITER_ONE;
            end else begin
                d_reg  <= d_reg;
                iter_r <= iter_r;
            end
            if (state_r == ST_SYND) begin
                syn_r  <= syn_s;
                mask_r <= mask_s;
            end else begin
                syn_r  <= syn_r;
                mask_r <= mask_r;
            end
        end
    end

    // Output registers: results are captured on the EVAL->DONE edge so they
    // are presented together with the out_valid pulse and then held.
    // ready follows the next state, so it stays low for one cycle after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_r     <= 1'b0;
            out_valid_r <= 1'b0;
            dec_ok_r    <= 1'b0;
            data_out_r  <= 27'd0;
            iter_cnt_r  <= {ITER_W{1'b0}};
        end else begin
            ready_r     <= (state_nxt == ST_IDLE);
            out_valid_r <= finish_s;
            if (finish_s) begin
                dec_ok_r   <= ok_s;
                data_out_r <= d_reg;
                iter_cnt_r <= iter_r;
            end else begin
                dec_ok_r   <= dec_ok_r;
                data_out_r <= data_out_r;
                iter_cnt_r <= iter_cnt_r;
            end
        end
    end

    assign bus.ready     = ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.dec_ok    = dec_ok_r;
    assign bus.data_out  = data_out_r;
    assign bus.iter_cnt  = iter_cnt_r;

endmodule

// File: tb/tb_qc_decoder.sv
// tb_qc_decoder: scoreboard bench for qc_decoder. Stimulus pushes the
// expected result (data, status, iteration count, absolute output cycle)
// into a per-DUT queue; monitors pop and compare on every out_valid.
// dut_a uses the default MAX_ITER, dut_b uses MAX_ITER = 0.
module tb_qc_decoder;

    typedef struct {
        string       name;
        logic [26:0] data;
        logic        ok;
        logic [3:0]  iter;
        int          cyc;
    } exp_t;

    localparam logic [26:0] D0 = 27'h5A5A5A5;
    localparam logic [26:0] D1 = 27'h1234567;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    logic [26:0][161:0] g_pat;

    qc_decoder_if #(.ITER_W(4)) bus_a();
    qc_decoder_if #(.ITER_W(4)) bus_b();

    qc_decoder #(.MAX_ITER(8), .ITER_W(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    qc_decoder #(.MAX_ITER(0), .ITER_W(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Cycle counter; stimulus and monitors read it away from the rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Encoder for the test code: p[j] = d[j mod 27].
    function automatic logic [188:0] encode(input logic [26:0] d);
        logic [188:0] w;
        w[188:162] = d;
        for (int j = 0; j < 162; j++) w[j] = d[j % 27];
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor for dut_a.
    always @(negedge clk) begin
        if (bus_a.out_valid === 1'b1) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_out_valid: got out_valid at cycle %0d, expected none", cyc);
            end else begin
                ea = qa.pop_front();
                chk({ea.name, ".data"}, {5'd0, bus_a.data_out}, {5'd0, ea.data});
                chk({ea.name, ".dec_ok"}, {31'd0, bus_a.dec_ok}, {31'd0, ea.ok});
                chk({ea.name, ".iter_cnt"}, {28'd0, bus_a.iter_cnt}, {28'd0, ea.iter});
                chk({ea.name, ".cycle"}, cyc, ea.cyc);
            end
        end
    end

    // Monitor for dut_b.
    always @(negedge clk) begin
        if (bus_b.out_valid === 1'b1) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_out_valid: got out_valid at cycle %0d, expected none", cyc);
            end else begin
                eb = qb.pop_front();
                chk({eb.name, ".data"}, {5'd0, bus_b.data_out}, {5'd0, eb.data});
                chk({eb.name, ".dec_ok"}, {31'd0, bus_b.dec_ok}, {31'd0, eb.ok});
                chk({eb.name, ".iter_cnt"}, {28'd0, bus_b.iter_cnt}, {28'd0, eb.iter});
                chk({eb.name, ".cycle"}, cyc, eb.cyc);
            end
        end
    end

    task automatic wait_ready(input bit sel);
        int n;
        n = 0;
        while (((sel ? bus_b.ready : bus_a.ready) !== 1'b1) && (n < 60)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 for 60 cycles, expected 1");
        end
    endtask

    // Issue one word and queue its expected result `lat` cycles after accept.
    task automatic send(input bit sel, input string nm, input logic [188:0] w,
                        input logic [26:0] ed, input logic eok, input logic [3:0] eit,
                        input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        wait_ready(sel);
        e.name = nm; e.data = ed; e.ok = eok; e.iter = eit; e.cyc = cyc + lat;
        if (sel) begin
            qb.push_back(e);
            bus_b.code_in = w;
            bus_b.valid   = 1'b1;
        end else begin
            qa.push_back(e);
            bus_a.code_in = w;
            bus_a.valid   = 1'b1;
        end
        @(posedge clk);
        #1;
        bus_a.valid = 1'b0;
        bus_b.valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks + 1, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [188:0] w;
        logic [188:0] w2;
        exp_t e;
        int c0;

        for (int i = 0; i < 27; i++)
            for (int j = 0; j < 162; j++)
                g_pat[i][j] = ((j % 27) == i);
        bus_a.g_rows = g_pat;  bus_b.g_rows = g_pat;
        bus_a.valid = 1'b0;    bus_b.valid = 1'b0;
        bus_a.code_in = '0;    bus_b.code_in = '0;
        rst = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", {31'd0, bus_a.ready}, 32'd0);
        chk("rst.out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("rst.data_out", {5'd0, bus_a.data_out}, 32'd0);
        chk("rst.dec_ok", {31'd0, bus_a.dec_ok}, 32'd0);
        chk("rst.iter_cnt", {28'd0, bus_a.iter_cnt}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_rel.ready_low", {31'd0, bus_a.ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_rel.ready_high", {31'd0, bus_a.ready}, 32'd1);

        // Clean word.
        w = encode(D0);
        send(1'b0, "clean", w, D0, 1'b1, 4'd0, 3);

        // Single information-bit error.
        w = encode(D0); w[165] = ~w[165];
        send(1'b0, "d3_err", w, D0, 1'b1, 4'd1, 5);

        // Single parity-bit error: no bit reaches majority, stuck.
        w = encode(D0); w[40] = ~w[40];
        send(1'b0, "p40_err", w, D0, 1'b0, 4'd0, 3);

        // Two information-bit errors, default iteration limit.
        w = encode(D0); w[162] = ~w[162]; w[188] = ~w[188];
        send(1'b0, "d0_d26_err", w, D0, 1'b1, 4'd1, 5);

        // Same word with MAX_ITER = 0: single check, no correction.
        send(1'b1, "d0_d26_max0", w, D0 ^ 27'h4000001, 1'b0, 4'd0, 3);

        // valid held high through a busy decode with a second word.
        w  = encode(D0);
        w2 = encode(D1); w2[172] = ~w2[172];
        @(posedge clk);
        #1;
        wait_ready(1'b0);
        c0 = cyc;
        e.name = "held_first";  e.data = D0; e.ok = 1'b1; e.iter = 4'd0; e.cyc = c0 + 3;
        qa.push_back(e);
        e.name = "held_second"; e.data = D1; e.ok = 1'b1; e.iter = 4'd1; e.cyc = c0 + 4 + 5;
        qa.push_back(e);
        bus_a.code_in = w;
        bus_a.valid   = 1'b1;
        @(posedge clk);
        #1;
        bus_a.code_in = w2;
        repeat (4) @(posedge clk);
        #1;
        bus_a.valid = 1'b0;

        // Reset in cycle 2 of a decode.
        w = encode(D1);
        @(posedge clk);
        #1;
        wait_ready(1'b0);
        bus_a.code_in = w;
        bus_a.valid   = 1'b1;
        @(posedge clk);
        #1;
        bus_a.valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst.ready", {31'd0, bus_a.ready}, 32'd0);
        chk("mid_rst.out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("mid_rst.data_out", {5'd0, bus_a.data_out}, 32'd0);
        chk("mid_rst.dec_ok", {31'd0, bus_a.dec_ok}, 32'd0);
        chk("mid_rst.iter_cnt", {28'd0, bus_a.iter_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst.ready_after", {31'd0, bus_a.ready}, 32'd1);

        // Fresh word after reset.
        w = encode(D1); w[170] = ~w[170];
        send(1'b0, "post_rst", w, D1, 1'b1, 4'd1, 5);

        repeat (40) @(posedge clk);
        #1;
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
